// File: rtl/per_timer_pkg.sv
// Shared bus encodings, register offsets and CTRL layout for the timer/PWM peripheral.
// Also provides the CTRL packing helper used by the read path.
package per_timer_pkg;

    localparam int MemAddressWidth = 32;
    localparam int MemByteWidth    = 32;
    localparam int SelectModeWidth = 2;

    typedef logic [MemAddressWidth-1:0] mem_addr_t;
    typedef logic [MemByteWidth-1:0]    mem_byte_t;
    typedef logic [SelectModeWidth-1:0] select_mode_t;
    typedef logic [7:0]                 timer_prescale_t;

    localparam select_mode_t SelectAsNone   = 2'd0;
    localparam select_mode_t SelectAsMaster = 2'd1;
    localparam select_mode_t SelectAsDevice = 2'd2;

    localparam logic RWInoutR = 1'b0;
    localparam logic RWInoutW = 1'b1;

    // Word offsets as seen on addr_in[4:2]
    localparam logic [2:0] TimerCtrlOff   = 3'd0;
    localparam logic [2:0] TimerCountOff  = 3'd1;
    localparam logic [2:0] TimerCmpOff    = 3'd2;
    localparam logic [2:0] TimerStatusOff = 3'd3;
    localparam logic [2:0] TimerDutyOff   = 3'd4;

    localparam int TimerCtrlEnBit       = 0;
    localparam int TimerCtrlReloadBit   = 1;
    localparam int TimerCtrlIrqEnBit    = 2;
    localparam int TimerCtrlPwmEnBit    = 3;
    localparam int TimerCtrlPrescaleLsb = 8;

    typedef struct packed {
        timer_prescale_t prescale;
        logic            pwm_en;
        logic            irq_en;
        logic            reload;
        logic            en;
    } ctrl_t;

    function automatic mem_byte_t pack_ctrl(input ctrl_t c);
        mem_byte_t v;
        v = '0;
        v[TimerCtrlEnBit]     = c.en;
        v[TimerCtrlReloadBit] = c.reload;
        v[TimerCtrlIrqEnBit]  = c.irq_en;
        v[TimerCtrlPwmEnBit]  = c.pwm_en;
        v[TimerCtrlPrescaleLsb +: 8] = c.prescale;
        return v;
    endfunction

    function automatic ctrl_t unpack_ctrl(input mem_byte_t v);
        ctrl_t c;
        c.en       = v[TimerCtrlEnBit];
        c.reload   = v[TimerCtrlReloadBit];
        c.irq_en   = v[TimerCtrlIrqEnBit];
        c.pwm_en   = v[TimerCtrlPwmEnBit];
        c.prescale = v[TimerCtrlPrescaleLsb +: 8];
        return c;
    endfunction

endpackage

// File: rtl/per_timer_if.sv
// xSimBus device-side signal bundle: single-cycle accesses, no wait states, never stalls.
interface per_timer_if;
    import per_timer_pkg::*;

    select_mode_t select_as_in;
    mem_addr_t    addr_in;
    mem_byte_t    data_in;
    mem_byte_t    data_out;
    logic         rw_in;

    modport master (
        output select_as_in,
        output addr_in,
        output data_in,
        output rw_in,
        input  data_out
    );

    modport slave (
        input  select_as_in,
        input  addr_in,
        input  data_in,
        input  rw_in,
        output data_out
    );

endinterface

// File: rtl/per_timer_prescaler.sv
// 8-bit prescaler: tick is combinational in the cycle the count equals limit (period limit+1).
// Clear forces the count to 0 and suppresses that cycle's tick; no backpressure.
module per_timer_prescaler
    import per_timer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clear,
    input  timer_prescale_t limit,
    output logic            tick
);

    timer_prescale_t cnt;

    assign tick = en && !clear && (cnt == limit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == limit) ? 8'd0 : cnt + 8'd1;
        end
    end

endmodule

// File: rtl/per_timer.sv
// Timer/PWM bus responder: 0-cycle reads, writes commit on the selecting edge, pwm_out registered.
// Every access completes in one cycle; the bus is never held.
module per_timer
    import per_timer_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    per_timer_if.slave   bus,
    output logic         irq_out,
    output logic         pwm_out
);

    ctrl_t     ctrl;
    mem_byte_t count;
    mem_byte_t cmp;
    mem_byte_t duty;
    logic      match;
    logic      tick;

    logic       sel;
    logic       wr;
    logic [2:0] off;
    logic       wr_ctrl;
    logic       wr_count;
    logic       wr_cmp;
    logic       wr_status;
    logic       wr_duty;
    logic       hit;

    assign sel       = (bus.select_as_in == SelectAsDevice);
    assign wr        = sel && (bus.rw_in == RWInoutW);
    assign off       = bus.addr_in[4:2];
    assign wr_ctrl   = wr && (off == TimerCtrlOff);
    assign wr_count  = wr && (off == TimerCountOff);
    assign wr_cmp    = wr && (off == TimerCmpOff);
    assign wr_status = wr && (off == TimerStatusOff);
    assign wr_duty   = wr && (off == TimerDutyOff);
    assign hit       = (count == cmp);

    logic unused_addr;
    assign unused_addr = &{1'b0, bus.addr_in[MemAddressWidth-1:5], bus.addr_in[1:0]};

    // A CTRL write clears the prescaler, which also masks the tick in that cycle
    per_timer_prescaler u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (ctrl.en),
        .clear (wr_ctrl),
        .limit (ctrl.prescale),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl    <= '0;
            count   <= '0;
            cmp     <= '0;
            duty    <= '0;
            match   <= 1'b0;
            pwm_out <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= unpack_ctrl(bus.data_in);
            end else if (tick && hit && !ctrl.reload) begin
                ctrl.en <= 1'b0;
            end

            if (wr_count) begin
                count <= bus.data_in;
            end else if (tick) begin
                if (hit) begin
                    if (ctrl.reload) begin
                        count <= '0;
                    end
                end else begin
                    count <= count + 32'd1;
                end
            end

            if (wr_cmp) begin
                cmp <= bus.data_in;
            end

            if (wr_duty) begin
                duty <= bus.data_in;
            end

            // Setting beats a simultaneous write-1-clear
            if (tick && hit) begin
                match <= 1'b1;
            end else if (wr_status && bus.data_in[0]) begin
                match <= 1'b0;
            end

            pwm_out <= ctrl.pwm_en && (count < duty);
        end
    end

    assign irq_out = match && ctrl.irq_en;

    always_comb begin
        bus.data_out = '0;
        if (sel) begin
            case (off)
                TimerCtrlOff:   bus.data_out = pack_ctrl(ctrl);
                TimerCountOff:  bus.data_out = count;
                TimerCmpOff:    bus.data_out = cmp;
                TimerStatusOff: bus.data_out = {31'd0, match};
                TimerDutyOff:   bus.data_out = duty;
                default:        bus.data_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_per_timer.sv
// Directed bench for per_timer: register table plus timed sequences for match, prescale, PWM and collisions.
module tb_per_timer;
    import per_timer_pkg::*;

    logic clk;
    logic rst;
    logic irq_out;
    logic pwm_out;

    per_timer_if bus ();

    per_timer dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .irq_out (irq_out),
        .pwm_out (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_COUNT  = 5'h04;
    localparam logic [4:0] OFF_CMP    = 5'h08;
    localparam logic [4:0] OFF_STATUS = 5'h0C;
    localparam logic [4:0] OFF_DUTY   = 5'h10;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        select_mode_t sel;
        logic [4:0]   off;
        logic [31:0]  wdat;
        logic [4:0]   rd_off;
        logic [31:0]  exp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Called at a falling edge; drives the access, lets the rising edge commit it, returns at the next falling edge
    task automatic bus_write(input select_mode_t s, input logic [4:0] off, input logic [31:0] d);
        bus.select_as_in = s;
        bus.rw_in        = RWInoutW;
        bus.addr_in      = {27'd0, off};
        bus.data_in      = d;
        @(negedge clk);
        bus.select_as_in = SelectAsNone;
        bus.rw_in        = RWInoutR;
        bus.data_in      = '0;
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] d);
        bus_write(SelectAsDevice, off, d);
    endtask

    task automatic bus_read(input logic [4:0] off, output logic [31:0] d);
        bus.select_as_in = SelectAsDevice;
        bus.rw_in        = RWInoutR;
        bus.addr_in      = {27'd0, off};
        #1;
        d = bus.data_out;
        bus.select_as_in = SelectAsNone;
    endtask

    task automatic read_check(input string name, input logic [4:0] off, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(off, d);
        check(name, d, exp);
    endtask

    task automatic quiesce();
        wr(OFF_CTRL, 32'h0);
        wr(OFF_COUNT, 32'h0);
        wr(OFF_STATUS, 32'h1);
    endtask

    initial begin
        rst              = 1'b0;
        bus.select_as_in = SelectAsNone;
        bus.rw_in        = RWInoutR;
        bus.addr_in      = '0;
        bus.data_in      = '0;

        vecs[0] = '{"cmp_rw",        SelectAsDevice, OFF_CMP,   32'h0000_1234, OFF_CMP,   32'h0000_1234};
        vecs[1] = '{"duty_rw",       SelectAsDevice, OFF_DUTY,  32'hDEAD_BEEF, OFF_DUTY,  32'hDEAD_BEEF};
        vecs[2] = '{"ctrl_mask",     SelectAsDevice, OFF_CTRL,  32'hFFFF_FFF4, OFF_CTRL,  32'h0000_FF04};
        vecs[3] = '{"count_rw",      SelectAsDevice, OFF_COUNT, 32'h0000_0077, OFF_COUNT, 32'h0000_0077};
        vecs[4] = '{"off18_zero",    SelectAsDevice, 5'h18,     32'hFFFF_FFFF, 5'h18,     32'h0};
        vecs[5] = '{"sel_none_wr",   SelectAsNone,   OFF_CMP,   32'h0000_5555, OFF_CMP,   32'h0000_1234};
        vecs[6] = '{"sel_master_wr", SelectAsMaster, OFF_DUTY,  32'h0000_0001, OFF_DUTY,  32'hDEAD_BEEF};
        vecs[7] = '{"off14_ignored", SelectAsDevice, 5'h14,     32'h0000_AAAA, OFF_CMP,   32'h0000_1234};
        vecs[8] = '{"off1c_zero",    SelectAsDevice, 5'h1C,     32'h0000_0001, 5'h1C,     32'h0};

        repeat (2) @(negedge clk);
        read_check("rst_ctrl",   OFF_CTRL,   32'h0);
        read_check("rst_count",  OFF_COUNT,  32'h0);
        read_check("rst_cmp",    OFF_CMP,    32'h0);
        read_check("rst_status", OFF_STATUS, 32'h0);
        read_check("rst_duty",   OFF_DUTY,   32'h0);
        check("rst_irq", {31'd0, irq_out}, 32'h0);
        check("rst_pwm", {31'd0, pwm_out}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            logic [31:0] d;
            bus_write(vecs[i].sel, vecs[i].off, vecs[i].wdat);
            bus_read(vecs[i].rd_off, d);
            check(vecs[i].name, d, vecs[i].exp);
        end
        bus.select_as_in = SelectAsNone;
        bus.addr_in      = {27'd0, OFF_CMP};
        #1;
        check("unselected_read", bus.data_out, 32'h0);
        @(negedge clk);

        // One-shot: match on the 6th tick, EN self-clears, COUNT holds
        quiesce();
        wr(OFF_CMP, 32'd5);
        wr(OFF_CTRL, 32'h0000_0005);
        repeat (5) @(negedge clk);
        read_check("os_count5", OFF_COUNT, 32'd5);
        check("os_irq_before", {31'd0, irq_out}, 32'h0);
        @(negedge clk);
        check("os_irq_set", {31'd0, irq_out}, 32'h1);
        read_check("os_match", OFF_STATUS, 32'h1);
        read_check("os_ctrl_en_clr", OFF_CTRL, 32'h0000_0004);
        repeat (3) @(negedge clk);
        read_check("os_count_hold", OFF_COUNT, 32'd5);
        wr(OFF_STATUS, 32'h1);
        check("os_irq_clr", {31'd0, irq_out}, 32'h0);

        // Prescale 3 with reload at CMP=2
        quiesce();
        wr(OFF_CMP, 32'd2);
        wr(OFF_CTRL, 32'h0000_0303);
        for (int k = 1; k <= 24; k++) begin
            if (k == 14) wr(OFF_STATUS, 32'h1);
            else @(negedge clk);
            read_check($sformatf("ps_count_%0d", k), OFF_COUNT, ((k / 4) % 3));
            if (k == 11 || k == 23) read_check($sformatf("ps_nomatch_%0d", k), OFF_STATUS, 32'h0);
            if (k == 12 || k == 24) read_check($sformatf("ps_match_%0d", k), OFF_STATUS, 32'h1);
            if (k == 15) read_check("ps_match_cleared", OFF_STATUS, 32'h0);
        end

        // PWM: period 10, high while the previous cycle's COUNT < 3
        quiesce();
        wr(OFF_CMP, 32'd9);
        wr(OFF_DUTY, 32'd3);
        wr(OFF_CTRL, 32'h0000_000B);
        check("pwm_start", {31'd0, pwm_out}, 32'h0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check($sformatf("pwm_%0d", k), {31'd0, pwm_out}, {31'd0, (((k - 1) % 10) < 3)});
        end

        // COUNT write in a tick cycle wins
        quiesce();
        wr(OFF_CMP, 32'h1000);
        wr(OFF_CTRL, 32'h0000_0001);
        @(negedge clk);
        wr(OFF_COUNT, 32'h100);
        read_check("col_count_wr", OFF_COUNT, 32'h100);

        // Match set and write-1-clear in the same cycle
        quiesce();
        wr(OFF_CMP, 32'h10);
        wr(OFF_COUNT, 32'h10);
        wr(OFF_CTRL, 32'h0000_0003);
        read_check("col_pre_match", OFF_STATUS, 32'h0);
        wr(OFF_STATUS, 32'h1);
        read_check("col_set_wins", OFF_STATUS, 32'h1);

        // Wrap from all-ones to zero without a flag
        quiesce();
        wr(OFF_CMP, 32'h10);
        wr(OFF_COUNT, 32'hFFFF_FFFF);
        wr(OFF_CTRL, 32'h0000_0001);
        @(negedge clk);
        read_check("wrap_count", OFF_COUNT, 32'h0);
        read_check("wrap_noflag", OFF_STATUS, 32'h0);

        // Asynchronous reset mid-count
        quiesce();
        wr(OFF_CMP, 32'h1000);
        wr(OFF_DUTY, 32'h20);
        wr(OFF_CTRL, 32'h0000_000B);
        repeat (5) @(negedge clk);
        read_check("arst_pre_count", OFF_COUNT, 32'd5);
        check("arst_pre_pwm", {31'd0, pwm_out}, 32'h1);
        rst = 1'b0;
        #1;
        read_check("arst_count", OFF_COUNT, 32'h0);
        check("arst_pwm", {31'd0, pwm_out}, 32'h0);
        read_check("arst_ctrl", OFF_CTRL, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/per_timer.md
# per_timer

Memory-mapped timer/PWM peripheral that acts as a bus responder (slave device) on xSimBus, the counterpart to the CPU core's master port. It decodes device-selected read/write cycles to a small register file and runs a prescaled 32-bit up-counter with compare-match. It drives a level interrupt and a PWM output, usable as the SoC `led_out`.

## Interface
- No parameters; widths come from `defines.v` (`MemAddressBus`, `MemByteBus` = 32 bit, `SelectModeBus`).
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `select_as_in`  in  `SelectModeBus`  bus selection; the block responds only when it equals `SelectAsDevice`.
- `addr_in`  in  `MemAddressBus`  bus device address; only `addr_in[4:2]` is decoded.
- `data_in`  in  `MemByteBus`  bus write data.
- `data_out`  out  `MemByteBus`  read data.
- `rw_in`  in  1  `RWInoutW` = write, `RWInoutR` = read.
- `irq_out`  out  1  level interrupt.
- `pwm_out`  out  1  PWM output.

## Operation
- Register map (byte offset):
  - 0x00 CTRL: bit0 EN, bit1 RELOAD, bit2 IRQ_EN, bit3 PWM_EN, [15:8] PRESCALE; other bits read 0.
  - 0x04 COUNT.
  - 0x08 CMP.
  - 0x0C STATUS: bit0 MATCH, sticky; a write of 1 clears it.
  - 0x10 DUTY.
  - Offsets 0x14–0x1C read 0; writes to them are ignored.
- Selected read: `data_out` is the addressed register, combinational from `addr_in`. When not selected, `data_out` = 0.
- Selected write: commits at the rising edge of the cycle in which the block is selected.
- Any CTRL write clears the prescaler count to 0.
- Prescaler:
  - EN=0: the 8-bit prescaler and COUNT hold their values.
  - EN=1: the prescaler increments each cycle. When it equals PRESCALE it returns to 0 and produces a one-cycle internal `tick`. A `tick` therefore occurs every PRESCALE+1 cycles; PRESCALE=0 gives a tick every cycle.
- On `tick`:
  - If COUNT==CMP: MATCH is set. With RELOAD=1, COUNT becomes 0. With RELOAD=0, COUNT holds and EN is cleared (one-shot).
  - Otherwise COUNT increments modulo 2^32; 0xFFFFFFFF wraps to 0 with no flag.
- `irq_out` = MATCH & IRQ_EN (combinational from registers).
- `pwm_out` is registered: PWM_EN & (COUNT < DUTY), unsigned comparison.
- Simultaneous events:
  - A bus write to COUNT or CTRL in a tick cycle wins over the tick update.
  - A MATCH set in the same cycle as a write-1-clear leaves MATCH at 1.
  - Writing CMP equal to the current COUNT matches on the next tick.
- Reads have no side effects.

## Timing
- Reset (`rst`=0, asynchronous) forces all registers, the prescaler, `pwm_out` and `irq_out` to 0, and `data_out` to 0. Reset may assert mid-count; outputs clear immediately.
- Read latency is 0 cycles: data is valid in the same cycle as select and address.
- Write latency is 1 edge: the new value is visible on a read in the following cycle.
- `irq_out` rises in the cycle after the tick edge that sets MATCH. It falls in the cycle after the clearing write, or after a CTRL write with IRQ_EN=0.
- `pwm_out` lags COUNT by 1 cycle.
- The block never holds the bus: every access completes in one cycle.

## Structure
- Add to `defines.v`: offsets `TimerCtrlOff`..`TimerDutyOff`, CTRL bit positions, and `TimerPrescaleBus` [7:0].
- One sub-module, `per_timer_prescaler`: an 8-bit counter with inputs en/clear/limit and output `tick`.
- Register file, decode and compare logic stay in `per_timer`. Estimated size is about 180 lines.

## Test plan
- Reset value: with `rst`=0, all five registers read 0, and `irq_out`=0, `pwm_out`=0.
- One-shot match:
  - Stimulus: CMP=5, then CTRL=0x0000_0005 (EN, IRQ_EN, PRESCALE=0).
  - Response: MATCH and `irq_out` become 1 on the 6th tick. COUNT holds at 5 and CTRL.EN reads 0. Writing STATUS=1 drops `irq_out` the next cycle.
- Prescale and reload:
  - Stimulus: CMP=2, CTRL=0x0000_0303 (EN, RELOAD, PRESCALE=3).
  - Response: COUNT advances every 4 cycles in the sequence 0,1,2,0,1,…, and MATCH sets every 12 cycles.
- PWM:
  - Stimulus: CMP=9, DUTY=3, CTRL=0x0000_000B (EN, RELOAD, PWM_EN).
  - Response: `pwm_out` has a period of 10 cycles, high for 3 cycles, lagging COUNT by one.
- Collisions:
  - A COUNT=0x100 write in a tick cycle reads back 0x100.
  - A STATUS=1 write in the cycle that sets MATCH leaves MATCH=1.
  - COUNT=0xFFFFFFFF with CMP=0x10 wraps to 0 on the next tick.
- Decode and select:
  - A write with `select_as_in`=`SelectAsNone` or `SelectAsMaster` changes nothing.
  - A read of offset 0x18 returns 0.
  - `rst` asserted mid-count clears COUNT and `pwm_out` without waiting for a clock edge.
